pipeline_hazard_unit: RTL and testbench

- Parametrised hazard detection and forwarding controller for the 5-stage IF/ID/EX/MEM/WB core.
- Generates stall, flush and bubble controls for the pipeline registers, plus operand forwarding selects for EX.
- Adds a configurable load-use latency, a redirect shadow for the synchronous instruction memory, multi-cycle memory wait handling, and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_unit.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and operand forwarding for the 5-stage IF/ID/EX/MEM/WB core.
// Latency: controls and forwarding selects are combinational (0 cycles); load/shadow state is registered.
// Backpressure: a memory wait freezes the whole front end; load-use stalls hold PC and IF/ID while bubbling EX.
//
// Ports:
//   clk, rst                          core clock, asynchronous active-high reset
//   id_* / ex_* / mem_* / wb_*        per-stage valid, write-enable, load flag and register selects
//   mem_ready                         memory access complete (0 with mem_valid = wait)
//   branch_redirect                   EX resolved a taken branch/jump
//   stall_if/id/ex/mem                hold PC, IF/ID, ID/EX, EX/MEM registers
//   flush_id, bubble_ex               bubble into IF/ID, ID/EX
//   fwd_a_sel, fwd_b_sel              EX operand source: 0 RF, 1 EX/MEM, 2 MEM/WB, 3 WB data
//   stall_cycles, flush_events        saturating performance counters
module pipeline_hazard_unit #(
    parameter int unsigned REG_AW          = 5,
    parameter int unsigned LOAD_LATENCY    = 0,
    parameter int unsigned REDIRECT_SHADOW = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_ready,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              branch_redirect,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

    localparam logic [2:0]       LW_INIT = 3'(LOAD_LATENCY);
    localparam logic [1:0]       SH_INIT = 2'(REDIRECT_SHADOW);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    // With no extra load latency a load in MEM already has its data available.
    localparam logic             MEM_LOAD_FWD_OK = (LOAD_LATENCY == 0);
    localparam logic             HAS_LOAD_WAIT   = (LOAD_LATENCY > 0);

    logic [0:0]       state_q,  state_d;
    logic [2:0]       lw_cnt_q, lw_cnt_d;
    logic [1:0]       sh_cnt_q, sh_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

    function automatic logic src_match(
        input logic              stage_valid,
        input logic              stage_wen,
        input logic [REG_AW-1:0] stage_rd,
        input logic [REG_AW-1:0] rs,
        input logic              rs_used
    );
        return stage_valid && stage_wen && (stage_rd != '0) && (stage_rd == rs) && rs_used;
    endfunction

    function automatic logic [1:0] fwd_pick(
        input logic ex_m,
        input logic mem_m,
        input logic wb_m
    );
        if (ex_m && !ex_is_load)                          return 2'd1;
        else if (mem_m && (!mem_is_load || MEM_LOAD_FWD_OK)) return 2'd2;
        else if (wb_m)                                    return 2'd3;
        else                                              return 2'd0;
    endfunction

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic mem_wait, redirect, shadow_active, load_use;
    logic st_if, st_id, st_ex, st_mem, fl_id, bb_ex;

    assign ex_m1  = src_match(ex_valid,  ex_wen,  ex_rd,  id_rs1, id_rs1_used);
    assign ex_m2  = src_match(ex_valid,  ex_wen,  ex_rd,  id_rs2, id_rs2_used);
    assign mem_m1 = src_match(mem_valid, mem_wen, mem_rd, id_rs1, id_rs1_used);
    assign mem_m2 = src_match(mem_valid, mem_wen, mem_rd, id_rs2, id_rs2_used);
    assign wb_m1  = src_match(wb_valid,  wb_wen,  wb_rd,  id_rs1, id_rs1_used);
    assign wb_m2  = src_match(wb_valid,  wb_wen,  wb_rd,  id_rs2, id_rs2_used);

    assign mem_wait      = mem_valid && !mem_ready;
    // A redirect during a memory wait is dropped; EX holds and presents it again afterwards.
    assign redirect      = branch_redirect && !mem_wait;
    assign shadow_active = (sh_cnt_q != 2'd0) && !mem_wait;
    assign load_use      = ex_is_load && (ex_m1 || ex_m2) && id_valid;

    // Pipeline controls and next state, in priority order.
    always_comb begin
        st_if    = 1'b0;
        st_id    = 1'b0;
        st_ex    = 1'b0;
        st_mem   = 1'b0;
        fl_id    = 1'b0;
        bb_ex    = 1'b0;
        state_d  = state_q;
        lw_cnt_d = lw_cnt_q;
        sh_cnt_d = sh_cnt_q;
        if (mem_wait) begin
            st_if  = 1'b1;
            st_id  = 1'b1;
            st_ex  = 1'b1;
            st_mem = 1'b1;
        end else if (redirect) begin
            fl_id    = 1'b1;
            bb_ex    = 1'b1;
            sh_cnt_d = SH_INIT;
            state_d  = ST_RUN;
            lw_cnt_d = 3'd0;
        end else if (shadow_active) begin
            // The ID slot is being flushed, so any hazard it carries is moot.
            fl_id    = 1'b1;
            sh_cnt_d = sh_cnt_q - 2'd1;
        end else if (state_q == ST_LOAD_WAIT) begin
            st_if    = 1'b1;
            st_id    = 1'b1;
            bb_ex    = 1'b1;
            lw_cnt_d = lw_cnt_q - 3'd1;
            if (lw_cnt_q == 3'd1) begin
                state_d = ST_RUN;
            end
        end else if (load_use) begin
            st_if = 1'b1;
            st_id = 1'b1;
            bb_ex = 1'b1;
            if (HAS_LOAD_WAIT) begin
                state_d  = ST_LOAD_WAIT;
                lw_cnt_d = LW_INIT;
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    always_comb begin
        stall_if  = st_if  && !rst;
        stall_id  = st_id  && !rst;
        stall_ex  = st_ex  && !rst;
        stall_mem = st_mem && !rst;
        flush_id  = fl_id  && !rst;
        bubble_ex = bb_ex  && !rst;
        fwd_a_sel = rst ? 2'd0 : fwd_pick(ex_m1, mem_m1, wb_m1);
        fwd_b_sel = rst ? 2'd0 : fwd_pick(ex_m2, mem_m2, wb_m2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            lw_cnt_q       <= 3'd0;
            sh_cnt_q       <= 2'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q  <= state_d;
            lw_cnt_q <= lw_cnt_d;
            sh_cnt_q <= sh_cnt_d;
            if (st_if && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_ONE;
            end
            if (redirect && (flush_events_q != '1)) begin
                flush_events_q <= flush_events_q + CNT_ONE;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2;
    logic       ex_valid, ex_wen, ex_is_load;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_wen, mem_is_load;
    logic [4:0] mem_rd;
    logic       mem_ready;
    logic       wb_valid, wb_wen;
    logic [4:0] wb_rd;
    logic       branch_redirect;

    logic        a_stall_if, a_stall_id, a_stall_ex, a_stall_mem, a_flush_id, a_bubble_ex;
    logic [1:0]  a_fwd_a_sel, a_fwd_b_sel;
    logic [15:0] a_stall_cycles, a_flush_events;
    logic        b_stall_if, b_stall_id, b_stall_ex, b_stall_mem, b_flush_id, b_bubble_ex;
    logic [1:0]  b_fwd_a_sel, b_fwd_b_sel;
    logic [3:0]  b_stall_cycles, b_flush_events;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    pipeline_hazard_unit #(.REG_AW(5), .LOAD_LATENCY(2), .REDIRECT_SHADOW(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .branch_redirect(branch_redirect),
        .stall_if(a_stall_if), .stall_id(a_stall_id), .stall_ex(a_stall_ex), .stall_mem(a_stall_mem),
        .flush_id(a_flush_id), .bubble_ex(a_bubble_ex),
        .fwd_a_sel(a_fwd_a_sel), .fwd_b_sel(a_fwd_b_sel),
        .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
    );

    pipeline_hazard_unit #(.REG_AW(5), .LOAD_LATENCY(3), .REDIRECT_SHADOW(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .branch_redirect(branch_redirect),
        .stall_if(b_stall_if), .stall_id(b_stall_id), .stall_ex(b_stall_ex), .stall_mem(b_stall_mem),
        .flush_id(b_flush_id), .bubble_ex(b_bubble_ex),
        .fwd_a_sel(b_fwd_a_sel), .fwd_b_sel(b_fwd_b_sel),
        .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = 0;
        mem_valid = 0; mem_wen = 0; mem_is_load = 0; mem_rd = 0; mem_ready = 1;
        wb_valid = 0; wb_wen = 0; wb_rd = 0;
        branch_redirect = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    // EX holds a load to x7 and ID reads x7 through rs2.
    task automatic set_load_use();
        id_valid = 1; id_rs2_used = 1; id_rs2 = 7;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 7;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_load_use();
        mem_valid = 1; mem_ready = 0;
        wb_valid = 1; wb_wen = 1; wb_rd = 7;
        rst = 1;
        #2;
        checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall_if: got %b want 0", a_stall_if); end
        checks++; if (a_stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall_mem: got %b want 0", a_stall_mem); end
        checks++; if (a_bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble_ex: got %b want 0", a_bubble_ex); end
        checks++; if (a_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL reset_fwd_b: got %0d want 0", a_fwd_b_sel); end
        checks++; if (a_stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", a_stall_cycles); end
        checks++; if (a_flush_events !== 16'd0) begin errors++; $display("FAIL reset_flush_events: got %0d want 0", a_flush_events); end
        cyc();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        id_valid = 1; id_rs1_used = 1; id_rs1 = 5;
        ex_valid = 1; ex_wen = 1; ex_rd = 5;
        #1;
        checks++; if (a_fwd_a_sel !== 2'd1) begin errors++; $display("FAIL fwd_ex: got %0d want 1", a_fwd_a_sel); end
        checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL fwd_ex_nostall: got %b want 0", a_stall_if); end
        checks++; if (a_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL fwd_b_unused: got %0d want 0", a_fwd_b_sel); end
        mem_valid = 1; mem_wen = 1; mem_rd = 5;
        #1;
        checks++; if (a_fwd_a_sel !== 2'd1) begin errors++; $display("FAIL fwd_ex_over_mem: got %0d want 1", a_fwd_a_sel); end
        ex_valid = 0;
        #1;
        checks++; if (a_fwd_a_sel !== 2'd2) begin errors++; $display("FAIL fwd_mem: got %0d want 2", a_fwd_a_sel); end
        mem_valid = 0;
        wb_valid = 1; wb_wen = 1; wb_rd = 5;
        #1;
        checks++; if (a_fwd_a_sel !== 2'd3) begin errors++; $display("FAIL fwd_wb: got %0d want 3", a_fwd_a_sel); end
        wb_valid = 0;
        ex_valid = 1; ex_rd = 0; id_rs1 = 0;
        #1;
        checks++; if (a_fwd_a_sel !== 2'd0) begin errors++; $display("FAIL fwd_x0: got %0d want 0", a_fwd_a_sel); end
        ex_valid = 0;
        id_rs2_used = 1; id_rs2 = 9;
        mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_rd = 9;
        wb_valid = 1; wb_wen = 1; wb_rd = 9;
        #1;
        checks++; if (a_fwd_b_sel !== 2'd3) begin errors++; $display("FAIL fwd_mem_load_skip: got %0d want 3", a_fwd_b_sel); end
        id_rs2_used = 0;
        #1;
        checks++; if (a_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL fwd_rs2_unused: got %0d want 0", a_fwd_b_sel); end
        clear_inputs();
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        checks++; if ({a_stall_if, a_stall_id, a_bubble_ex} !== 3'b111) begin errors++; $display("FAIL lu_c0: got %b want 111", {a_stall_if, a_stall_id, a_bubble_ex}); end
        checks++; if ({a_stall_ex, a_stall_mem, a_flush_id} !== 3'b000) begin errors++; $display("FAIL lu_c0_other: got %b want 000", {a_stall_ex, a_stall_mem, a_flush_id}); end
        for (int k = 1; k <= 2; k++) begin
            cyc();
            ex_valid = 0; ex_wen = 0; ex_is_load = 0;
            mem_valid = (k == 1); mem_wen = (k == 1); mem_is_load = (k == 1); mem_rd = 7;
            wb_valid = (k == 2); wb_wen = (k == 2); wb_rd = 7;
            #1;
            checks++; if ({a_stall_if, a_stall_id, a_bubble_ex} !== 3'b111) begin errors++; $display("FAIL lu_wait c%0d: got %b want 111", k, {a_stall_if, a_stall_id, a_bubble_ex}); end
            if (k == 1) begin
                checks++; if (a_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL lu_mem_load_nofwd: got %0d want 0", a_fwd_b_sel); end
            end
        end
        cyc();
        mem_valid = 0; mem_wen = 0; mem_is_load = 0;
        wb_valid = 1; wb_wen = 1; wb_rd = 7;
        #1;
        checks++; if ({a_stall_if, a_stall_id, a_bubble_ex} !== 3'b000) begin errors++; $display("FAIL lu_release: got %b want 000", {a_stall_if, a_stall_id, a_bubble_ex}); end
        checks++; if (a_fwd_b_sel !== 2'd3) begin errors++; $display("FAIL lu_fwd_wb: got %0d want 3", a_fwd_b_sel); end
        checks++; if (a_stall_cycles !== 16'd3) begin errors++; $display("FAIL lu_stall_cycles: got %0d want 3", a_stall_cycles); end
        checks++; if (b_stall_if !== 1'b1) begin errors++; $display("FAIL lu3_still: got %b want 1", b_stall_if); end
        cyc();
        #1;
        checks++; if (b_stall_if !== 1'b0) begin errors++; $display("FAIL lu3_release: got %b want 0", b_stall_if); end
        checks++; if (b_stall_cycles !== 4'd4) begin errors++; $display("FAIL lu3_stall_cycles: got %0d want 4", b_stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        branch_redirect = 1;
        #1;
        checks++; if ({a_flush_id, a_bubble_ex, a_stall_if} !== 3'b110) begin errors++; $display("FAIL rd_c0: got %b want 110", {a_flush_id, a_bubble_ex, a_stall_if}); end
        cyc();
        branch_redirect = 0;
        set_load_use();
        #1;
        checks++; if ({a_flush_id, a_bubble_ex, a_stall_if} !== 3'b100) begin errors++; $display("FAIL rd_shadow: got %b want 100", {a_flush_id, a_bubble_ex, a_stall_if}); end
        checks++; if (a_flush_events !== 16'd1) begin errors++; $display("FAIL rd_flush_events: got %0d want 1", a_flush_events); end
        cyc();
        #1;
        checks++; if (a_flush_id !== 1'b0) begin errors++; $display("FAIL rd_shadow_end: got %b want 0", a_flush_id); end
        checks++; if (a_stall_if !== 1'b1) begin errors++; $display("FAIL rd_lu_after_shadow: got %b want 1", a_stall_if); end
        checks++; if (a_flush_events !== 16'd1) begin errors++; $display("FAIL rd_flush_events_hold: got %0d want 1", a_flush_events); end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_valid = 1; mem_ready = 0; branch_redirect = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({a_stall_if, a_stall_id, a_stall_ex, a_stall_mem} !== 4'b1111) begin errors++; $display("FAIL mw_stall c%0d: got %b want 1111", i, {a_stall_if, a_stall_id, a_stall_ex, a_stall_mem}); end
            checks++; if ({a_flush_id, a_bubble_ex} !== 2'b00) begin errors++; $display("FAIL mw_noflush c%0d: got %b want 00", i, {a_flush_id, a_bubble_ex}); end
            cyc();
        end
        checks++; if (a_flush_events !== 16'd0) begin errors++; $display("FAIL mw_no_event: got %0d want 0", a_flush_events); end
        mem_ready = 1;
        #1;
        checks++; if ({a_flush_id, a_bubble_ex, a_stall_mem} !== 3'b110) begin errors++; $display("FAIL mw_accept: got %b want 110", {a_flush_id, a_bubble_ex, a_stall_mem}); end
        cyc();
        branch_redirect = 0; mem_valid = 0;
        #1;
        checks++; if (a_flush_events !== 16'd1) begin errors++; $display("FAIL mw_flush_events: got %0d want 1", a_flush_events); end
        checks++; if (a_stall_cycles !== 16'd4) begin errors++; $display("FAIL mw_stall_cycles: got %0d want 4", a_stall_cycles); end
        checks++; if (a_flush_id !== 1'b1) begin errors++; $display("FAIL mw_shadow: got %b want 1", a_flush_id); end
        clear_inputs();
    endtask

    task automatic test_redirect_in_load_wait();
        do_reset();
        set_load_use();
        #1;
        checks++; if (b_stall_if !== 1'b1) begin errors++; $display("FAIL rlw_c0: got %b want 1", b_stall_if); end
        cyc();
        ex_valid = 0; ex_is_load = 0;
        #1;
        checks++; if (b_stall_if !== 1'b1) begin errors++; $display("FAIL rlw_c1: got %b want 1", b_stall_if); end
        cyc();
        branch_redirect = 1;
        #1;
        checks++; if ({b_stall_if, b_flush_id, b_bubble_ex} !== 3'b011) begin errors++; $display("FAIL rlw_redirect: got %b want 011", {b_stall_if, b_flush_id, b_bubble_ex}); end
        cyc();
        branch_redirect = 0;
        #1;
        checks++; if ({b_stall_if, b_flush_id, b_bubble_ex} !== 3'b010) begin errors++; $display("FAIL rlw_shadow: got %b want 010", {b_stall_if, b_flush_id, b_bubble_ex}); end
        cyc();
        #1;
        checks++; if ({b_stall_if, b_flush_id, b_bubble_ex} !== 3'b000) begin errors++; $display("FAIL rlw_run: got %b want 000", {b_stall_if, b_flush_id, b_bubble_ex}); end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_valid = 1; mem_ready = 0;
        repeat (20) cyc();
        #1;
        checks++; if (b_stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_b: got %0d want 15", b_stall_cycles); end
        checks++; if (a_stall_cycles !== 16'd20) begin errors++; $display("FAIL sat_a: got %0d want 20", a_stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_load_wait();
        clear_inputs();
        set_load_use();
        wb_valid = 1; wb_wen = 1; wb_rd = 7;
        cyc();
        #1;
        checks++; if (b_stall_if !== 1'b1) begin errors++; $display("FAIL rst_lw_pre: got %b want 1", b_stall_if); end
        #3;
        rst = 1;
        #1;
        checks++; if ({b_stall_if, b_stall_id, b_bubble_ex} !== 3'b000) begin errors++; $display("FAIL rst_async_ctl: got %b want 000", {b_stall_if, b_stall_id, b_bubble_ex}); end
        checks++; if (b_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL rst_async_fwd: got %0d want 0", b_fwd_b_sel); end
        checks++; if (b_stall_cycles !== 4'd0) begin errors++; $display("FAIL rst_async_cnt_b: got %0d want 0", b_stall_cycles); end
        checks++; if (a_stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_async_cnt_a: got %0d want 0", a_stall_cycles); end
        cyc();
        rst = 0;
        clear_inputs();
        #1;
        checks++; if (b_stall_if !== 1'b0) begin errors++; $display("FAIL rst_state_run: got %b want 0", b_stall_if); end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_redirect_in_load_wait();
        test_saturation();
        test_reset_mid_load_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
